// File: rtl/parity_command_issuer.sv
// PSL command issuer: credit-limited command launch with per-tag pending tracking,
// odd-parity generation on the command bus, and response-to-completion forwarding.
module parity_command_issuer #(
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  croom,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [12:0] req_command,
  input  logic [63:0] req_address,
  input  logic [7:0]  req_tag,
  input  logic [11:0] req_size,
  output logic        cmd_valid,
  output logic [12:0] cmd_command,
  output logic [63:0] cmd_address,
  output logic [7:0]  cmd_tag,
  output logic [11:0] cmd_size,
  output logic        cmd_command_parity,
  output logic        cmd_address_parity,
  output logic        cmd_tag_parity,
  output logic [2:0]  cmd_abt,
  output logic [15:0] cmd_context_handle,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_tag,
  input  logic [7:0]  rsp_code,
  output logic        done_valid,
  output logic [7:0]  done_tag,
  output logic [7:0]  done_code,
  output logic [7:0]  outstanding,
  output logic        tag_error
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [7:0] MAX_CREDITS = 8'(MAX_OUTSTANDING);

  state_t       state_reg, state_next;
  logic [7:0]   credits_reg, credits_next;
  logic [7:0]   outstanding_reg, outstanding_next;
  logic [255:0] pending_reg;
  logic         transfer;
  logic         rsp_match;
  logic [7:0]   load_credits;

  logic        cmd_valid_reg;
  logic [12:0] cmd_command_reg;
  logic [63:0] cmd_address_reg;
  logic [7:0]  cmd_tag_reg;
  logic [11:0] cmd_size_reg;
  logic        done_valid_reg;
  logic [7:0]  done_tag_reg;
  logic [7:0]  done_code_reg;
  logic        tag_error_reg;

  assign load_credits = (croom > MAX_CREDITS) ? MAX_CREDITS : croom;
  assign transfer     = req_valid & req_ready;
  assign rsp_match    = rsp_valid & pending_reg[rsp_tag];

  // Pending is the registered bitmap, so a tag answered this cycle cannot be reissued until the next.
  always_comb begin
    req_ready = (state_reg == RUN) & enable & (credits_reg != 8'd0) & ~pending_reg[req_tag];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (!enable && outstanding_reg == 8'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    credits_next     = credits_reg;
    outstanding_next = outstanding_reg;
    if (state_reg == LOAD) begin
      credits_next = load_credits;
    end else begin
      if (transfer)  credits_next = credits_next - 8'd1;
      if (rsp_match) credits_next = credits_next + 8'd1;
    end
    if (transfer)  outstanding_next = outstanding_next + 8'd1;
    if (rsp_match) outstanding_next = outstanding_next - 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      credits_reg     <= 8'd0;
      outstanding_reg <= 8'd0;
      tag_error_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      credits_reg     <= credits_next;
      outstanding_reg <= outstanding_next;
      if (rsp_valid && !pending_reg[rsp_tag]) tag_error_reg <= 1'b1;
    end
  end

  // One flop per tag; a transfer and a matched response never target the same tag.
  generate
    for (genvar gi = 0; gi < 256; gi++) begin : g_pending
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          pending_reg[gi] <= 1'b0;
        end else if (transfer && req_tag == 8'(gi)) begin
          pending_reg[gi] <= 1'b1;
        end else if (rsp_match && rsp_tag == 8'(gi)) begin
          pending_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_valid_reg   <= 1'b0;
      cmd_command_reg <= 13'd0;
      cmd_address_reg <= 64'd0;
      cmd_tag_reg     <= 8'd0;
      cmd_size_reg    <= 12'd0;
    end else begin
      cmd_valid_reg <= transfer;
      if (transfer) begin
        cmd_command_reg <= req_command;
        cmd_address_reg <= req_address;
        cmd_tag_reg     <= req_tag;
        cmd_size_reg    <= req_size;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_valid_reg <= 1'b0;
      done_tag_reg   <= 8'd0;
      done_code_reg  <= 8'd0;
    end else begin
      done_valid_reg <= rsp_match;
      if (rsp_match) begin
        done_tag_reg  <= rsp_tag;
        done_code_reg <= rsp_code;
      end
    end
  end

  assign cmd_valid          = cmd_valid_reg;
  assign cmd_command        = cmd_command_reg;
  assign cmd_address        = cmd_address_reg;
  assign cmd_tag            = cmd_tag_reg;
  assign cmd_size           = cmd_size_reg;
  assign cmd_command_parity = ~^cmd_command_reg;
  assign cmd_address_parity = ~^cmd_address_reg;
  assign cmd_tag_parity     = ~^cmd_tag_reg;
  assign cmd_abt            = 3'd0;
  assign cmd_context_handle = 16'd0;
  assign done_valid         = done_valid_reg;
  assign done_tag           = done_tag_reg;
  assign done_code          = done_code_reg;
  assign outstanding        = outstanding_reg;
  assign tag_error          = tag_error_reg;

endmodule

// File: tb/tb_parity_command_issuer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// tag-set / credit-count reference model.
module tb_parity_command_issuer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  croom;
  logic        req_valid;
  logic        req_ready;
  logic [12:0] req_command;
  logic [63:0] req_address;
  logic [7:0]  req_tag;
  logic [11:0] req_size;
  logic        cmd_valid;
  logic [12:0] cmd_command;
  logic [63:0] cmd_address;
  logic [7:0]  cmd_tag;
  logic [11:0] cmd_size;
  logic        cmd_command_parity;
  logic        cmd_address_parity;
  logic        cmd_tag_parity;
  logic [2:0]  cmd_abt;
  logic [15:0] cmd_context_handle;
  logic        rsp_valid;
  logic [7:0]  rsp_tag;
  logic [7:0]  rsp_code;
  logic        done_valid;
  logic [7:0]  done_tag;
  logic [7:0]  done_code;
  logic [7:0]  outstanding;
  logic        tag_error;

  localparam int MAXO = 64;

  parity_command_issuer #(.MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset), .enable(enable), .croom(croom),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_command(req_command), .req_address(req_address), .req_tag(req_tag), .req_size(req_size),
    .cmd_valid(cmd_valid), .cmd_command(cmd_command), .cmd_address(cmd_address),
    .cmd_tag(cmd_tag), .cmd_size(cmd_size),
    .cmd_command_parity(cmd_command_parity), .cmd_address_parity(cmd_address_parity),
    .cmd_tag_parity(cmd_tag_parity), .cmd_abt(cmd_abt), .cmd_context_handle(cmd_context_handle),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_code(rsp_code),
    .done_valid(done_valid), .done_tag(done_tag), .done_code(done_code),
    .outstanding(outstanding), .tag_error(tag_error)
  );

  always #5 clock = ~clock;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: phase 0=idle, 1=load, 2=running; pending tags as a set.
  int          m_phase;
  int          m_credits;
  int          m_out;
  bit          m_pend[256];
  logic [7:0]  inflight[$];
  logic        m_tag_err;
  logic        m_cmd_valid;
  logic [12:0] m_cmd_command;
  logic [63:0] m_cmd_address;
  logic [7:0]  m_cmd_tag;
  logic [11:0] m_cmd_size;
  logic        m_done_valid;
  logic [7:0]  m_done_tag;
  logic [7:0]  m_done_code;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else checks_passed++;
  endtask

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_par(input logic [63:0] v);
    return ($countones(v) % 2) == 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_credits = 0; m_out = 0; m_tag_err = 1'b0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    inflight.delete();
    m_cmd_valid = 1'b0; m_cmd_command = '0; m_cmd_address = '0; m_cmd_tag = '0; m_cmd_size = '0;
    m_done_valid = 1'b0; m_done_tag = '0; m_done_code = '0;
  endtask

  task automatic check_outputs();
    check("cmd_valid", cmd_valid, m_cmd_valid);
    check("cmd_tag", cmd_tag, m_cmd_tag);
    check("cmd_command", cmd_command, m_cmd_command);
    check("cmd_address", cmd_address, m_cmd_address);
    check("cmd_size", cmd_size, m_cmd_size);
    check("cmd_command_parity", cmd_command_parity, odd_par(64'(m_cmd_command)));
    check("cmd_address_parity", cmd_address_parity, odd_par(m_cmd_address));
    check("cmd_tag_parity", cmd_tag_parity, odd_par(64'(m_cmd_tag)));
    check("cmd_abt", cmd_abt, 0);
    check("cmd_context_handle", cmd_context_handle, 0);
    check("done_valid", done_valid, m_done_valid);
    check("done_tag", done_tag, m_done_tag);
    check("done_code", done_code, m_done_code);
    check("outstanding", outstanding, m_out);
    check("tag_error", tag_error, m_tag_err);
  endtask

  // One clock cycle: predict from the inputs held across the edge, then compare after it.
  task automatic step();
    bit exp_ready, xfer, rsp_ok;
    @(negedge clock);
    exp_ready = (m_phase == 2) && enable && (m_credits > 0) && !m_pend[req_tag];
    check("req_ready", req_ready, exp_ready);
    xfer   = req_valid && exp_ready;
    rsp_ok = rsp_valid && m_pend[rsp_tag];
    case (m_phase)
      0: if (enable) m_phase = 1;
      1: begin m_credits = (croom > MAXO) ? MAXO : int'(croom); m_phase = 2; end
      default: if (!enable && m_out == 0) m_phase = 0;
    endcase
    if (rsp_valid && !rsp_ok) m_tag_err = 1'b1;
    m_done_valid = rsp_ok;
    if (rsp_ok) begin
      m_done_tag = rsp_tag; m_done_code = rsp_code;
      m_pend[rsp_tag] = 1'b0; m_credits++; m_out--;
      foreach (inflight[i]) if (inflight[i] == rsp_tag) begin inflight.delete(i); break; end
    end
    m_cmd_valid = xfer;
    if (xfer) begin
      m_cmd_command = req_command; m_cmd_address = req_address;
      m_cmd_tag = req_tag; m_cmd_size = req_size;
      m_pend[req_tag] = 1'b1; m_credits--; m_out++;
      inflight.push_back(req_tag);
    end
    @(posedge clock);
    #1;
    check_outputs();
    $display("cyc: req v=%0b t=%0h rdy=%0b | rsp v=%0b t=%0h | cmd v=%0b t=%0h | done v=%0b t=%0h | out=%0d err=%0b",
             req_valid, req_tag, exp_ready, rsp_valid, rsp_tag, cmd_valid, cmd_tag,
             done_valid, done_tag, outstanding, tag_error);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    enable = 1'b0; idle_inputs();
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_req_ready", req_ready, 0);
    check_outputs();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [7:0] room);
    croom = room; enable = 1'b1;
    step(); step();
  endtask

  task automatic offer(input logic [7:0] tag, input logic [63:0] addr, input logic [12:0] cmd);
    req_valid = 1'b1; req_tag = tag; req_address = addr; req_command = cmd;
    req_size = 12'($urandom);
  endtask

  task automatic respond(input logic [7:0] tag);
    rsp_valid = 1'b1; rsp_tag = tag; rsp_code = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    enable = 1'b0;
    while (m_phase != 0 && n < 400) begin
      req_valid = 1'($urandom_range(0, 1)); req_tag = 8'($urandom_range(0, 15));
      if (inflight.size() > 0 && $urandom_range(0, 1) == 1)
        respond(inflight[$urandom_range(0, inflight.size() - 1)]);
      else rsp_valid = 1'b0;
      step();
      n++;
    end
    if (m_phase != 0) check("drain_timeout", outstanding, 0);
    idle_inputs();
  endtask

  initial begin
    croom = 8'd0; req_command = '0; req_address = '0; req_tag = '0; req_size = '0;
    rsp_tag = '0; rsp_code = '0;
    do_reset();

    // Basic issue
    start(8'd4);
    offer(8'h01, 64'h1000, 13'h0A00);
    step();
    idle_inputs();
    check("basic_cmd_addr", cmd_address, 64'h1000);
    check("basic_cmd_command", cmd_command, 13'h0A00);
    check("basic_outstanding", outstanding, 1);
    check("basic_tag_parity", cmd_tag_parity, 0);
    step();
    check("basic_cmd_valid_drop", cmd_valid, 0);
    drain();

    // Credit exhaustion
    do_reset();
    start(8'd2);
    offer(8'h00, 64'h2000, 13'h0001); step();
    offer(8'h01, 64'h2080, 13'h0002); step();
    offer(8'h02, 64'h2100, 13'h0003);
    step();
    check("exhaust_ready_low", req_ready, 0);
    respond(8'h00);
    step();
    rsp_valid = 1'b0;
    step();
    check("exhaust_third_issued", cmd_tag, 8'h02);
    check("exhaust_third_valid", cmd_valid, 1);
    idle_inputs();
    drain();

    // Simultaneous transfer and response
    do_reset();
    start(8'd4);
    offer(8'h03, 64'h3000, 13'h0010); step();
    offer(8'h05, 64'h3040, 13'h0011); respond(8'h03);
    step();
    idle_inputs();
    check("simul_outstanding", outstanding, 1);
    check("simul_done_tag", done_tag, 8'h03);
    check("simul_cmd_tag", cmd_tag, 8'h05);

    // Unexpected response
    respond(8'h77);
    step();
    rsp_valid = 1'b0;
    check("unexp_tag_error", tag_error, 1);
    check("unexp_no_done", done_valid, 0);
    step();
    check("unexp_sticky", tag_error, 1);
    drain();

    // Duplicate tag
    do_reset();
    start(8'd4);
    offer(8'h10, 64'h4000, 13'h0020); step();
    step();
    check("dup_blocked", req_ready, 0);
    step();
    respond(8'h10);
    step();
    rsp_valid = 1'b0;
    step();
    check("dup_accepted", cmd_valid, 1);
    check("dup_tag", cmd_tag, 8'h10);
    idle_inputs();
    drain();

    // Reset mid-operation
    do_reset();
    start(8'd8);
    offer(8'h20, 64'h5000, 13'h0030); step();
    offer(8'h21, 64'h5040, 13'h0031); step();
    offer(8'h22, 64'h5080, 13'h0032); step();
    check("midrst_outstanding", outstanding, 3);
    do_reset();
    respond(8'h21);
    step();
    rsp_valid = 1'b0;
    check("midrst_tag_error", tag_error, 1);

    // Randomized rounds
    for (int r = 0; r < 20; r++) begin
      do_reset();
      start(($urandom_range(0, 4) == 0) ? 8'($urandom_range(60, 255)) : 8'($urandom_range(0, 8)));
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 2) != 0) offer(8'($urandom_range(0, 15)), {$urandom, $urandom}, 13'($urandom));
        else req_valid = 1'b0;
        if (inflight.size() > 0 && $urandom_range(0, 9) < 4)
          respond(inflight[$urandom_range(0, inflight.size() - 1)]);
        else if ($urandom_range(0, 39) == 0)
          respond(8'($urandom));
        else
          rsp_valid = 1'b0;
        step();
      end
      drain();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/parity_command_issuer.md
PARITY_COMMAND_ISSUER -- requirements
Module: parity_command_issuer

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 64, which caps the number of in-flight commands (1..255).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1 bit: job running; when low, no new request is accepted.
REQ-005 SHALL have port croom, input, 8 bits: PSL command credit count, static while enable is high.
REQ-006 SHALL have port req_valid, input, 1 bit: upstream work element offers a command.
REQ-007 SHALL have port req_ready, output, 1 bit: issuer accepts the offered command this cycle.
REQ-008 SHALL have ports req_command (13 bits), req_address (64 bits), req_tag (8 bits) and req_size (12 bits), all inputs: the fields of the offered command.
REQ-009 SHALL have ports cmd_valid (1 bit), cmd_command (13 bits), cmd_address (64 bits), cmd_tag (8 bits) and cmd_size (12 bits), all outputs: the PSL command bus.
REQ-010 SHALL have ports cmd_command_parity, cmd_address_parity and cmd_tag_parity, outputs, 1 bit each: odd parity of the matching field.
REQ-011 SHALL have ports cmd_abt (3 bits) and cmd_context_handle (16 bits), outputs: constant zero.
REQ-012 SHALL have ports rsp_valid (1 bit), rsp_tag (8 bits) and rsp_code (8 bits), all inputs: the PSL response bus.
REQ-013 SHALL have ports done_valid (1 bit), done_tag (8 bits) and done_code (8 bits), all outputs: the completion returned upstream.
REQ-014 SHALL have port outstanding, output, 8 bits: current number of in-flight commands.
REQ-015 SHALL have port tag_error, output, 1 bit: sticky flag for an unexpected response tag.

Function
REQ-016 SHALL implement states IDLE, LOAD and RUN; reset enters IDLE.
REQ-017 SHALL go IDLE->LOAD on the first cycle enable=1 and LOAD->RUN unconditionally one cycle later.
REQ-018 SHALL, in LOAD, set credits = min(croom, MAX_OUTSTANDING); croom=0 loads 0 credits and the block never issues.
REQ-019 SHALL return RUN->IDLE when enable=0 and outstanding=0; while enable=0 with outstanding>0 it stays in RUN, takes no requests, and still processes responses.
REQ-020 SHALL drive req_ready combinationally = (state==RUN) & enable & (credits>0) & !pending[req_tag].
REQ-021 SHALL define a transfer as req_valid & req_ready at edge N; cmd_valid is then high for exactly cycle N+1 with the registered request fields (latency 1).
REQ-022 SHALL allow back-to-back transfers: one per cycle while credits remain.
REQ-023 SHALL hold the cmd_* fields at their last value when cmd_valid=0.
REQ-024 SHALL hold a 256-entry pending bitmap indexed by tag; a transfer sets pending[req_tag].
REQ-025 SHALL, on rsp_valid with pending[rsp_tag]=1, clear the bit, increment credits, and pulse done_valid at the next cycle with done_tag=rsp_tag and done_code=rsp_code.
REQ-026 SHALL, on rsp_valid with pending[rsp_tag]=0, set tag_error, produce no done pulse, and leave credits and the bitmap unchanged.
REQ-027 SHALL, when a transfer and a valid response occur in the same cycle, leave the credit count net unchanged; if the tags are equal, the request is blocked by REQ-020 because pending is the registered value.
REQ-028 SHALL drive outstanding = population of the pending bitmap, kept as a counter: +1 on transfer, -1 on valid response, net 0 when both occur.
REQ-029 SHALL compute cmd_*_parity = XNOR-reduce of the registered field, combinational from the cmd_* registers.
REQ-030 SHALL keep credits within 0..MAX_OUTSTANDING; a response can never overflow credits because REQ-026 filters unmatched responses.

Reset
REQ-031 SHALL, on reset assertion, asynchronously force: cmd_valid=0, done_valid=0, req_ready=0, cmd_command/address/tag/size=0, done_tag=0, done_code=0, outstanding=0, credits=0, bitmap all zero, tag_error=0, state IDLE.
REQ-032 SHALL, after reset mid-operation, discard all in-flight tags; later responses to them set tag_error.

Verification
REQ-033 SHALL cover basic issue: croom=4, enable=1, request tag 0x01 address 0x1000 command 0x0A00 -> cmd_valid one cycle later with the same fields, outstanding=1, cmd_tag_parity=0.
REQ-034 SHALL cover credit exhaustion: croom=2, three back-to-back requests -> two issued, req_ready=0 on the third; a response to tag 0x00 -> third request issued the next cycle.
REQ-035 SHALL cover a simultaneous event: transfer of tag 0x05 in the same cycle as a response to tag 0x03 -> credits unchanged, outstanding unchanged, done_tag=0x03.
REQ-036 SHALL cover an unexpected response: rsp_tag=0x77 not pending -> tag_error=1 sticky, no done_valid, outstanding unchanged.
REQ-037 SHALL cover a duplicate tag: request tag 0x10 while 0x10 is pending -> req_ready=0 until its response, then accepted.
REQ-038 SHALL cover reset mid-operation: reset asserted with 3 outstanding -> all outputs zero immediately, IDLE; a subsequent response to a discarded tag -> tag_error=1.
